// File: rtl/gate_check_pkg.sv
`default_nettype none
// ============================================================================
// gate_check_pkg : shared widths, FSM state type and expected-table lookup
// Rev 1.0
// ============================================================================
package gate_check_pkg;

    localparam int VEC_W  = 4;
    localparam int RESP_W = 3;
    localparam int ERR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Entry i of the table occupies bits [3i+2:3i] and holds {X,Y,Z}
    function automatic logic [RESP_W-1:0] exp_lookup(
        input logic [16*RESP_W-1:0] tbl,
        input logic [VEC_W-1:0]     vec
    );
        return tbl[RESP_W*int'(vec) +: RESP_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_delay_line.sv
`default_nettype none
// ============================================================================
// vec_delay_line : DEPTH-stage valid+data shift register aligning vectors
// with the DUT response that appears DEPTH cycles later.  Rev 1.0
// ============================================================================
module vec_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign valid_d[g] = valid_i;
                assign data_d[g]  = data_i;
            end else begin : g_tail
                assign valid_d[g] = valid_q[g-1];
                assign data_d[g]  = data_q[g-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// gate_response_checker : applies-and-checks a gate DUT against EXP_TABLE,
// counting mismatches and latching the first failing vector.  Rev 1.0
// ============================================================================
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int                     NUM_VECTORS = 10,
    parameter int                     SETTLE      = 1,
    parameter logic [16*RESP_W-1:0]   EXP_TABLE   = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              vec_valid_i,
    input  logic [VEC_W-1:0]  vec_in_i,
    input  logic [RESP_W-1:0] resp_in_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              mismatch_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [VEC_W-1:0]  first_err_vec_o,
    output logic [RESP_W-1:0] first_err_resp_o
);

    state_e             state_q, state_d;
    logic [15:0]        vec_cnt_q, vec_cnt_d;
    logic [2:0]         drain_cnt_q, drain_cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   fvec_q, fvec_d;
    logic [RESP_W-1:0]  fresp_q, fresp_d;
    logic               mis_q, mis_d;

    logic               start_run;
    logic               accept;
    logic               last_vec;
    logic               drain_end;
    logic               dl_valid;
    logic [VEC_W-1:0]   dl_vec;
    logic               fail;

    assign start_run = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept    = (state_q == ST_RUN) && vec_valid_i;
    assign last_vec  = accept && (vec_cnt_q == 16'(NUM_VECTORS - 1));
    assign drain_end = (state_q == ST_DRAIN) && (drain_cnt_q == 3'(SETTLE - 1));

    vec_delay_line #(
        .DEPTH  (SETTLE),
        .DATA_W (VEC_W)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (start_run),
        .valid_i (accept),
        .data_i  (vec_in_i),
        .valid_o (dl_valid),
        .data_o  (dl_vec)
    );

    assign fail = (state_q == ST_RUN || state_q == ST_DRAIN) && dl_valid
                  && (resp_in_i != exp_lookup(EXP_TABLE, dl_vec));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)   state_d = ST_RUN;
            ST_RUN:   if (last_vec)  state_d = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_d = ST_DONE;
            ST_DONE:  if (start_i)   state_d = ST_RUN;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done_o = (state_q == ST_DONE);
        pass_o = (state_q == ST_DONE) && (err_q == '0);
    end

    always_comb begin
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        fvec_d      = fvec_q;
        fresp_d     = fresp_q;
        mis_d       = fail;
        if (start_run) begin
            vec_cnt_d   = '0;
            drain_cnt_d = '0;
            err_d       = '0;
            fvec_d      = '0;
            fresp_d     = '0;
        end else begin
            if (accept) begin
                vec_cnt_d = vec_cnt_q + 16'd1;
            end
            if (last_vec) begin
                drain_cnt_d = '0;
            end else if (state_q == ST_DRAIN) begin
                drain_cnt_d = drain_cnt_q + 3'd1;
            end
            // err_q is still zero exactly when this is the run's first mismatch
            if (fail) begin
                if (err_q == '0) begin
                    fvec_d  = dl_vec;
                    fresp_d = resp_in_i;
                end
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= '0;
            fvec_q      <= '0;
            fresp_q     <= '0;
            mis_q       <= 1'b0;
        end else begin
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            fvec_q      <= fvec_d;
            fresp_q     <= fresp_d;
            mis_q       <= mis_d;
        end
    end

    assign mismatch_o       = mis_q;
    assign err_count_o      = err_q;
    assign first_err_vec_o  = fvec_q;
    assign first_err_resp_o = fresp_q;

endmodule
`default_nettype wire

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The block SHALL provide parameter NUM_VECTORS, default 10, the number of vectors per run (1..65535).
REQ-002 The block SHALL provide parameter SETTLE, default 1, the cycles from vector applied to DUT response sampled (1..4).
REQ-003 The block SHALL provide parameter EXP_TABLE, default 48'h0, a 16-entry x 3-bit expected {X,Y,Z} table indexed by {A,B,C,D}; entry i is bits [3i+2:3i].
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 START  in  1  one-cycle request to begin a run.
REQ-007 VEC_VALID  in  1  VEC_IN is being applied to the DUT this cycle.
REQ-008 VEC_IN  in  4  applied {A,B,C,D} vector.
REQ-009 RESP_IN  in  3  DUT response {X,Y,Z}.
REQ-010 BUSY  out  1  high in RUN or DRAIN.
REQ-011 DONE  out  1  high in DONE state.
REQ-012 PASS  out  1  valid while DONE; 1 when ERR_COUNT==0.
REQ-013 MISMATCH  out  1  one-cycle pulse per failing comparison.
REQ-014 ERR_COUNT  out  8  mismatches this run, saturating.
REQ-015 FIRST_ERR_VEC  out  4  vector of first mismatch.
REQ-016 FIRST_ERR_RESP  out  3  response captured at first mismatch.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on START; same edge clears ERR_COUNT, FIRST_ERR_*, vector count and delay line.
REQ-019 In RUN each VEC_VALID SHALL push {1,VEC_IN} into a SETTLE-deep delay line and increment the vector count; cycles without VEC_VALID push {0,x}.
REQ-020 RUN->DRAIN on the edge accepting vector NUM_VECTORS; later VEC_VALID ignored.
REQ-021 DRAIN SHALL last SETTLE cycles, then ->DONE.
REQ-022 When the delay-line output is valid, RESP_IN SHALL be compared to EXP_TABLE[vec]; on inequality MISMATCH pulses in the following cycle and ERR_COUNT increments.
REQ-023 ERR_COUNT SHALL saturate at 255.
REQ-024 FIRST_ERR_VEC/FIRST_ERR_RESP SHALL capture only the first mismatch of a run and then hold.
REQ-025 DONE SHALL hold with PASS, counts and first-error fields stable until START, which restarts per REQ-018.
REQ-026 START in RUN or DRAIN SHALL be ignored; VEC_VALID in IDLE or DONE SHALL be ignored.
REQ-027 Simultaneous START and VEC_VALID in IDLE: START taken, vector not counted.

Reset
REQ-028 RST_N low SHALL force IDLE, clear delay line and counters; all outputs 0.
REQ-029 Reset mid-RUN or mid-DRAIN SHALL abandon the run without asserting DONE.

Structure
REQ-030 State enum, VEC_W=4, RESP_W=3, ERR_W=8 SHALL live in shared package gate_check_pkg.
REQ-031 The delay line SHALL be sub-module vec_delay_line (parameter DEPTH, valid+data).

Verification
REQ-032 EXP_TABLE matching DUT, 10 vectors 0000,1001,1000,0011,0100,1110,0111,1000,1110,1111 back-to-back -> DONE 10+SETTLE cycles after first vector, PASS=1, ERR_COUNT=0.
REQ-033 EXP_TABLE entry 3 corrupted, same stream -> ERR_COUNT=1, FIRST_ERR_VEC=4'b0011, one MISMATCH pulse, PASS=0.
REQ-034 NUM_VECTORS=300, all entries wrong -> ERR_COUNT=255, FIRST_ERR_VEC = first vector.
REQ-035 VEC_VALID with 2-cycle gaps, SETTLE=3 -> results identical to back-to-back run.
REQ-036 RST_N low after vector 5 -> all outputs 0, IDLE; new START gives clean run, PASS=1.
REQ-037 START during RUN and VEC_VALID in DONE -> no state change, counts unchanged.
